// File: rtl/fp_ulp_stepper.sv
// ULP stepper: walks a float toward a target one representable value at a time.
// fpNextAfter is the registered single-step engine driven by the stepper FSM.

module fpNextAfter #(
    parameter int FPWID = 52
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [FPWID-1:0] a,
    input  logic [FPWID-1:0] b,
    output logic [FPWID-1:0] o
);

    localparam int EW =
        (FPWID == 128 || FPWID == 96 || FPWID == 84 || FPWID == 80) ? 15 :
        (FPWID == 64 || FPWID == 52 || FPWID == 48 || FPWID == 44) ? 11 :
        (FPWID == 42 || FPWID == 40) ? 10 :
        (FPWID == 32) ? 8 :
        (FPWID == 24) ? 7 : 5;
    localparam int FW = FPWID - 1 - EW;

    logic             a_nan;
    logic             b_nan;
    logic             a_zero;
    logic             b_zero;
    logic             away;
    logic [FPWID-1:0] nxt;

    always_comb begin
        a_nan  = (&a[FPWID-2 -: EW]) && (|a[FW-1:0]);
        b_nan  = (&b[FPWID-2 -: EW]) && (|b[FW-1:0]);
        a_zero = ~|a[FPWID-2:0];
        b_zero = ~|b[FPWID-2:0];
        // same sign and larger magnitude target means growing |a|
        away   = (a[FPWID-1] == b[FPWID-1]) && (b[FPWID-2:0] > a[FPWID-2:0]);
        nxt    = a;
        if (a_nan)
            nxt = a;
        else if (b_nan)
            nxt = b;
        else if (a == b || (a_zero && b_zero))
            nxt = b;
        else if (a_zero)
            nxt = {b[FPWID-1], {(FPWID-2){1'b0}}, 1'b1};
        else if (away)
            nxt = a + FPWID'(1);
        else
            nxt = a - FPWID'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            o <= '0;
        else if (en)
            o <= nxt;
    end

endmodule

module fp_ulp_stepper #(
    parameter int FPWID = 52,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [FPWID-1:0] a,
    input  logic [FPWID-1:0] b,
    input  logic [CNTW-1:0]  cnt,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [FPWID-1:0] o,
    output logic [CNTW-1:0]  steps,
    output logic [1:0]       stop
);

    localparam int EW =
        (FPWID == 128 || FPWID == 96 || FPWID == 84 || FPWID == 80) ? 15 :
        (FPWID == 64 || FPWID == 52 || FPWID == 48 || FPWID == 44) ? 11 :
        (FPWID == 42 || FPWID == 40) ? 10 :
        (FPWID == 32) ? 8 :
        (FPWID == 24) ? 7 : 5;
    localparam int FW = FPWID - 1 - EW;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] STEP = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state;
    logic [FPWID-1:0] cur;
    logic [FPWID-1:0] tgt;
    logic [CNTW-1:0]  rem;
    logic [FPWID-1:0] eng_o;
    logic             step_en;
    logic             cur_nan;
    logic             tgt_nan;

    assign req_ready = rst_n && ce && (state == IDLE);
    assign res_valid = (state == DONE);
    assign step_en   = ce && (state == STEP);
    assign cur_nan   = (&cur[FPWID-2 -: EW]) && (|cur[FW-1:0]);
    assign tgt_nan   = (&tgt[FPWID-2 -: EW]) && (|tgt[FW-1:0]);

    fpNextAfter #(.FPWID(FPWID)) u_next (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (step_en),
        .a     (cur),
        .b     (tgt),
        .o     (eng_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cur   <= '0;
            tgt   <= '0;
            rem   <= '0;
            steps <= '0;
            o     <= '0;
            stop  <= 2'd0;
        end else if (ce) begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        cur   <= a;
                        tgt   <= b;
                        rem   <= cnt;
                        steps <= '0;
                        if (cnt == '0) begin
                            o     <= a;
                            stop  <= 2'd0;
                            state <= DONE;
                        end else begin
                            state <= STEP;
                        end
                    end
                end
                STEP: state <= WAIT;
                WAIT: begin
                    if (cur_nan || tgt_nan) begin
                        o     <= eng_o;
                        stop  <= 2'd2;
                        state <= DONE;
                    end else if (eng_o == cur) begin
                        o     <= cur;
                        stop  <= 2'd1;
                        state <= DONE;
                    end else begin
                        cur   <= eng_o;
                        steps <= steps + CNTW'(1);
                        rem   <= rem - CNTW'(1);
                        if (rem == CNTW'(1)) begin
                            o     <= eng_o;
                            stop  <= 2'd0;
                            state <= DONE;
                        end else begin
                            state <= STEP;
                        end
                    end
                end
                DONE: begin
                    if (res_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
